// File: rtl/sr_latch_checker.sv
// Cycle-based monitor for an SR latch: tracks the expected latch state from S/R and counts
// cycles where Q/Qbar disagree. Optional first-error capture is enabled by SRCHK_FIRST_ERR_EN.
module sr_latch_checker #(
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter int unsigned ERR_W         = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             S,
    input  logic             R,
    input  logic             Q,
    input  logic             Qbar,
    output logic             exp_Q,
    output logic             exp_valid,
    output logic             mismatch,
    output logic             invalid_seen,
    output logic [ERR_W-1:0] err_count,
    output logic [1:0]       state
`ifdef SRCHK_FIRST_ERR_EN
    ,
    output logic             first_err_valid,
    output logic [3:0]       first_err_info
`endif
);

    localparam logic [1:0] StUnknown = 2'd0;
    localparam logic [1:0] StTrack   = 2'd1;
    localparam logic [1:0] StSettle  = 2'd2;
    localparam logic [1:0] StInvalid = 2'd3;

    localparam logic [3:0]       SettleLoad = 4'(SETTLE_CYCLES);
    localparam logic [ERR_W-1:0] ErrMax     = '1;

    logic [1:0]       state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [1:0]       in_q;
    logic             exp_bit_q, exp_bit_d;
    logic             exp_valid_q, exp_valid_d;
    logic             mismatch_q, mismatch_d;
    logic             invalid_q, invalid_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic             change;
    logic             fail;

`ifdef SRCHK_FIRST_ERR_EN
    logic       fe_valid_q, fe_valid_d;
    logic [3:0] fe_info_q, fe_info_d;
`endif

    assign change = ({S, R} != in_q);
    // Case-inequality so an undriven or X output never passes as a match.
    assign fail   = (Q !== exp_bit_q) || (Qbar !== ~exp_bit_q);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        exp_bit_d   = exp_bit_q;
        exp_valid_d = exp_valid_q;
        invalid_d   = invalid_q;
        err_d       = err_q;
        mismatch_d  = 1'b0;
`ifdef SRCHK_FIRST_ERR_EN
        fe_valid_d  = fe_valid_q;
        fe_info_d   = fe_info_q;
`endif
        if (change) begin
            unique case ({S, R})
                2'b10: begin
                    exp_bit_d   = 1'b1;
                    exp_valid_d = 1'b1;
                end
                2'b01: begin
                    exp_bit_d   = 1'b0;
                    exp_valid_d = 1'b1;
                end
                2'b00: begin
                    // Leaving S=R=1 makes the latch race; its outcome is unknowable.
                    if (in_q == 2'b11) exp_valid_d = 1'b0;
                end
                2'b11: begin
                    state_d   = StInvalid;
                    invalid_d = 1'b1;
                end
            endcase
            if ({S, R} != 2'b11) begin
                state_d = StSettle;
                cnt_d   = SettleLoad;
            end
        end else begin
            case (state_q)
                StSettle: begin
                    if (cnt_q <= 4'd1) begin
                        cnt_d   = 4'd0;
                        state_d = exp_valid_q ? StTrack : StUnknown;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
                StTrack: begin
                    if (fail) begin
                        mismatch_d = 1'b1;
                        if (err_q != ErrMax) err_d = err_q + ERR_W'(1);
`ifdef SRCHK_FIRST_ERR_EN
                        if (!fe_valid_q) begin
                            fe_valid_d = 1'b1;
                            fe_info_d  = {S, R, Q, Qbar};
                        end
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StUnknown;
            cnt_q       <= 4'd0;
            in_q        <= 2'b00;
            exp_bit_q   <= 1'b0;
            exp_valid_q <= 1'b0;
            mismatch_q  <= 1'b0;
            invalid_q   <= 1'b0;
            err_q       <= '0;
`ifdef SRCHK_FIRST_ERR_EN
            fe_valid_q  <= 1'b0;
            fe_info_q   <= 4'b0000;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            in_q        <= {S, R};
            exp_bit_q   <= exp_bit_d;
            exp_valid_q <= exp_valid_d;
            mismatch_q  <= mismatch_d;
            invalid_q   <= invalid_d;
            err_q       <= err_d;
`ifdef SRCHK_FIRST_ERR_EN
            fe_valid_q  <= fe_valid_d;
            fe_info_q   <= fe_info_d;
`endif
        end
    end

    assign state        = state_q;
    assign exp_Q        = exp_bit_q;
    assign exp_valid    = exp_valid_q;
    assign mismatch     = mismatch_q;
    assign invalid_seen = invalid_q;
    assign err_count    = err_q;
`ifdef SRCHK_FIRST_ERR_EN
    assign first_err_valid = fe_valid_q;
    assign first_err_info  = fe_info_q;
`endif

endmodule

// File: tb/tb_sr_latch_checker.sv
// Bench for sr_latch_checker: directed scenarios plus randomized S/R/fault traffic, checked
// each cycle against an age-since-change reference model.
module tb_sr_latch_checker;

    localparam int SETTLE = 2;
    localparam int EW     = 3;
    localparam int ERRMAX = (1 << EW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          S = 1'b0, R = 1'b0, Q = 1'b0, Qbar = 1'b1;
    logic          exp_Q, exp_valid, mismatch, invalid_seen;
    logic [EW-1:0] err_count;
    logic [1:0]    state;
`ifdef SRCHK_FIRST_ERR_EN
    logic          first_err_valid;
    logic [3:0]    first_err_info;
`endif

    sr_latch_checker #(.SETTLE_CYCLES(SETTLE), .ERR_W(EW)) dut (
        .clk(clk), .rst(rst), .S(S), .R(R), .Q(Q), .Qbar(Qbar),
        .exp_Q(exp_Q), .exp_valid(exp_valid), .mismatch(mismatch),
        .invalid_seen(invalid_seen), .err_count(err_count), .state(state)
`ifdef SRCHK_FIRST_ERR_EN
        , .first_err_valid(first_err_valid), .first_err_info(first_err_info)
`endif
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;

    // Reference model: expectations derive from edges elapsed since the last input change.
    int         age    = 1000;
    logic [1:0] m_prev = 2'b00;
    logic       m_q = 1'b0, m_valid = 1'b0, m_mm = 1'b0, m_inv = 1'b0;
    int         m_err  = 0;
    logic       m_fev  = 1'b0;
    logic [3:0] m_fei  = 4'b0000;
    logic       lq     = 1'b0;

    task automatic model_update(input logic s, r, q, qb);
        logic f;
        if (rst) begin
            age = 1000; m_prev = 2'b00; m_q = 0; m_valid = 0; m_mm = 0; m_inv = 0;
            m_err = 0; m_fev = 0; m_fei = 4'b0000;
        end else begin
            m_mm = 1'b0;
            if ({s, r} != m_prev) begin
                age = 0;
                if (s && !r) begin m_q = 1; m_valid = 1; end
                else if (!s && r) begin m_q = 0; m_valid = 1; end
                else if (!s && !r && m_prev == 2'b11) m_valid = 0;
                else if (s && r) m_inv = 1;
            end else begin
                if (age < 1000) age++;
                if (!(s && r) && m_valid && age > SETTLE) begin
                    f = (q !== m_q) || (qb !== ~m_q);
                    m_mm = f;
                    if (f) begin
                        m_err = (m_err < ERRMAX) ? m_err + 1 : ERRMAX;
                        if (!m_fev) begin m_fev = 1; m_fei = {s, r, q, qb}; end
                    end
                end
            end
            m_prev = {s, r};
        end
    endtask

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        assert (got === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %0h expected %0h (vector %0d)", tag, got, exp, n_vec);
        end
    endtask

    task automatic check_all();
        logic [1:0] es;
        if (m_prev == 2'b11) es = 2'd3;
        else if (age < SETTLE) es = 2'd2;
        else es = m_valid ? 2'd1 : 2'd0;
        chk("state", 8'(state), 8'(es));
        chk("exp_Q", 8'(exp_Q), 8'(m_q));
        chk("exp_valid", 8'(exp_valid), 8'(m_valid));
        chk("mismatch", 8'(mismatch), 8'(m_mm));
        chk("invalid_seen", 8'(invalid_seen), 8'(m_inv));
        chk("err_count", 8'(err_count), 8'(m_err));
`ifdef SRCHK_FIRST_ERR_EN
        chk("first_err_valid", 8'(first_err_valid), 8'(m_fev));
        chk("first_err_info", 8'(first_err_info), 8'(m_fei));
`endif
    endtask

    task automatic step(input logic s, r, q, qb);
        S = s; R = r; Q = q; Qbar = qb;
        @(posedge clk);
        #1;
        model_update(s, r, q, qb);
        n_vec++;
        check_all();
    endtask

    // fault: 0 none, 1 invert Q, 2 X on Q, 3 invert Q and Qbar
    task automatic apply(input logic s, r, input int fault);
        logic q, qb;
        if (s && !r) lq = 1'b1;
        else if (r && !s) lq = 1'b0;
        q = lq; qb = ~lq;
        if (s && r) begin q = 1'b0; qb = 1'b0; end
        if (fault == 1 || fault == 3) q = ~q;
        if (fault == 3) qb = ~qb;
        if (fault == 2) q = 1'bx;
        step(s, r, q, qb);
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        for (int i = 0; i < n; i++) apply(1'b0, 1'b0, 0);
        rst = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        int in_v, len, errs_before;
        // Reset, then idle
        do_reset(2);
        chk("reset_state", 8'(state), 8'd0);
        chk("reset_err", 8'(err_count), 8'd0);
        for (int i = 0; i < 10; i++) apply(1'b0, 1'b0, 0);
        chk("idle_valid", 8'(exp_valid), 8'd0);

        // Set / hold / reset / hold with a healthy latch
        for (int i = 0; i < 10; i++) apply(1'b1, 1'b0, 0);
        chk("set_expq", 8'(exp_Q), 8'd1);
        for (int i = 0; i < 10; i++) apply(1'b0, 1'b0, 0);
        for (int i = 0; i < 10; i++) apply(1'b0, 1'b1, 0);
        chk("rst_expq", 8'(exp_Q), 8'd0);
        for (int i = 0; i < 10; i++) apply(1'b0, 1'b0, 0);
        chk("healthy_err", 8'(err_count), 8'd0);

        // Faulty latch: Q wrong on cycles 5..8 after the set edge
        do_reset(1);
        for (int i = 0; i < 12; i++) apply(1'b1, 1'b0, (i >= 5 && i < 9) ? 1 : 0);
        chk("fault_err", 8'(err_count), 8'd4);

        // Invalid input, race release, then a clean reset-direction
        for (int i = 0; i < 5; i++) apply(1'b1, 1'b1, int'($urandom_range(0, 3)));
        chk("inv_state", 8'(state), 8'd3);
        for (int i = 0; i < 6; i++) apply(1'b0, 1'b0, int'($urandom_range(0, 3)));
        chk("race_valid", 8'(exp_valid), 8'd0);
        chk("race_state", 8'(state), 8'd0);
        for (int i = 0; i < 5; i++) apply(1'b0, 1'b1, 0);
        chk("post_inv_state", 8'(state), 8'd1);
        chk("inv_sticky", 8'(invalid_seen), 8'd1);

        // X on Q while tracking
        errs_before = m_err;
        apply(1'b0, 1'b1, 2);
        apply(1'b0, 1'b1, 0);

        // Saturation: 12 failing compare cycles
        do_reset(1);
        for (int i = 0; i < 3; i++) apply(1'b1, 1'b0, 0);
        for (int i = 0; i < 12; i++) apply(1'b1, 1'b0, 1);
        chk("sat_err", 8'(err_count), 8'(ERRMAX));

        // Reset mid-settle
        apply(1'b0, 1'b1, 0);
        do_reset(1);
        chk("midsettle_state", 8'(state), 8'd0);
        apply(1'b0, 1'b0, 0);

`ifdef SRCHK_FIRST_ERR_EN
        for (int i = 0; i < 5; i++) apply(1'b0, 1'b1, 0);
        apply(1'b0, 1'b1, 3);
        chk("fe_info", 8'(first_err_info), 8'h06);
        apply(1'b0, 1'b1, 1);
        chk("fe_hold", 8'(first_err_info), 8'h06);
        do_reset(1);
        chk("fe_clear", 8'(first_err_valid), 8'd0);
`endif

        // Randomized traffic with occasional faults and resets
        for (int it = 0; it < 200; it++) begin
            if ($urandom_range(0, 29) == 0) do_reset(1);
            in_v = int'($urandom_range(0, 3));
            len  = int'($urandom_range(1, 7));
            for (int k = 0; k < len; k++)
                apply(in_v[1], in_v[0], ($urandom_range(0, 7) == 0) ? 1 : 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
